// File: rtl/mmio_alarm_pkg.sv
// Shared definitions for the memory-mapped equality-alarm responder:
// register offsets, CTRL bit positions, STATUS field positions and FSM states.
package mmio_alarm_pkg;

   // Register offsets from the window base (byte addresses, word aligned)
   localparam logic [31:0] OFF_CTRL   = 32'h00;
   localparam logic [31:0] OFF_CMP_A  = 32'h04;
   localparam logic [31:0] OFF_CMP_B  = 32'h08;
   localparam logic [31:0] OFF_STATUS = 32'h0C;
   localparam logic [31:0] OFF_HOLD   = 32'h10;

   // CTRL bit positions
   localparam int CTRL_ENABLE     = 0;
   localparam int CTRL_CLEAR      = 1;
   localparam int CTRL_AUTO_REARM = 2;

   // STATUS field positions
   localparam int STATUS_ALARME    = 0;
   localparam int STATUS_STATE_LSB = 1;
   localparam int STATUS_CNT_LSB   = 8;

   // Alarm FSM states; the codes are visible to software through STATUS[2:1]
   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_TRIPPED  = 2'd2,
      ST_LATCHED  = 2'd3
   } alarm_state_e;

endpackage

// File: rtl/mmio_alarm_regs.sv
// Register file of the alarm responder: window decode, combinational read mux,
// CTRL/CMP/HOLD storage and the write-only clear/disable pulses for the FSM.
//
// Bus protocol: there is no valid/ready handshake. The core presents addr every
// cycle; a store commits at the rising edge when mem_write && sel, and a load is
// answered combinationally in the same cycle through rdata (0 when !sel).
module mmio_alarm_regs
   import mmio_alarm_pkg::*;
#(
   parameter logic [31:0]       BASE_ADDR    = 32'h0000_0100,
   parameter int                HOLD_W       = 16,
   parameter logic [HOLD_W-1:0] DEFAULT_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_write,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic [31:0]       status,
   output logic              sel,
   output logic [31:0]       rdata,
   output logic              enable,
   output logic              auto_rearm,
   output logic [31:0]       cmp_a,
   output logic [31:0]       cmp_b,
   output logic [HOLD_W-1:0] hold,
   output logic              clear_pulse,
   output logic              disable_pulse
);

   logic [31:0]       off;
   logic              in_win;
   logic              wr;
   logic              ctrl_wr;
   logic              en_q;
   logic              ar_q;
   logic [31:0]       cmp_a_q;
   logic [31:0]       cmp_b_q;
   logic [HOLD_W-1:0] hold_q;

   assign off     = addr - BASE_ADDR;
   assign in_win  = (addr >= BASE_ADDR) && (off <= OFF_HOLD);
   assign sel     = in_win && (addr[1:0] == 2'b00);
   assign wr      = mem_write && sel;
   assign ctrl_wr = wr && (off == OFF_CTRL);

   // clear is never stored: it only exists during the cycle of the CTRL write
   assign clear_pulse   = ctrl_wr && wdata[CTRL_CLEAR];
   assign disable_pulse = ctrl_wr && !wdata[CTRL_ENABLE];

   assign enable     = en_q;
   assign auto_rearm = ar_q;
   assign cmp_a      = cmp_a_q;
   assign cmp_b      = cmp_b_q;
   assign hold       = hold_q;

   // Commit software stores to the writable registers; STATUS is read-only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q    <= 1'b0;
         ar_q    <= 1'b0;
         cmp_a_q <= '0;
         cmp_b_q <= '0;
         hold_q  <= DEFAULT_HOLD;
      end else if (wr) begin
         case (off)
            OFF_CTRL: begin
               en_q <= wdata[CTRL_ENABLE];
               ar_q <= wdata[CTRL_AUTO_REARM];
            end
            OFF_CMP_A: cmp_a_q <= wdata;
            OFF_CMP_B: cmp_b_q <= wdata;
            OFF_HOLD:  hold_q  <= wdata[HOLD_W-1:0];
            default: ;
         endcase
      end
   end

   // Single-cycle load path; unused bits and misses read as zero
   always_comb begin
      rdata = '0;
      if (sel) begin
         case (off)
            OFF_CTRL: begin
               rdata[CTRL_ENABLE]     = en_q;
               rdata[CTRL_AUTO_REARM] = ar_q;
            end
            OFF_CMP_A:  rdata = cmp_a_q;
            OFF_CMP_B:  rdata = cmp_b_q;
            OFF_STATUS: rdata = status;
            OFF_HOLD:   rdata[HOLD_W-1:0] = hold_q;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mmio_alarm_responder.sv
// Memory-mapped equality alarm on the data-memory bus. Owns the trip FSM,
// the hold timer and the saturating trip counter; registers live in mmio_alarm_regs.
// The FSM state is exported to software (and to checkers) through STATUS[2:1].
module mmio_alarm_responder
   import mmio_alarm_pkg::*;
#(
   parameter logic [31:0]       BASE_ADDR    = 32'h0000_0100,
   parameter int                HOLD_W       = 16,
   parameter logic [HOLD_W-1:0] DEFAULT_HOLD = 16'd4,
   parameter int                CNT_W        = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        sel,
   output logic [31:0] rdata,
   output logic        alarme,
   output logic        alarm_pulse
);

   logic              enable;
   logic              auto_rearm;
   logic [31:0]       cmp_a;
   logic [31:0]       cmp_b;
   logic [HOLD_W-1:0] hold;
   logic              clear_pulse;
   logic              disable_pulse;
   logic [31:0]       status;

   alarm_state_e      state_q, state_nx;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_nx;
   logic [CNT_W-1:0]  trip_cnt_q, trip_cnt_nx;
   logic              alarme_nx;
   logic              pulse_nx;

   mmio_alarm_regs #(
      .BASE_ADDR    (BASE_ADDR),
      .HOLD_W       (HOLD_W),
      .DEFAULT_HOLD (DEFAULT_HOLD)
   ) u_regs (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_write     (mem_write),
      .addr          (addr),
      .wdata         (wdata),
      .status        (status),
      .sel           (sel),
      .rdata         (rdata),
      .enable        (enable),
      .auto_rearm    (auto_rearm),
      .cmp_a         (cmp_a),
      .cmp_b         (cmp_b),
      .hold          (hold),
      .clear_pulse   (clear_pulse),
      .disable_pulse (disable_pulse)
   );

   // Assemble the read-only STATUS word from the live FSM outputs
   always_comb begin
      status = '0;
      status[STATUS_ALARME] = alarme;
      status[STATUS_STATE_LSB +: 2] = state_q;
      status[STATUS_CNT_LSB +: CNT_W] = trip_cnt_q;
   end

   // State, timer, counter and alarm outputs all update together at the edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_DISABLED;
         hold_cnt_q  <= '0;
         trip_cnt_q  <= '0;
         alarme      <= 1'b0;
         alarm_pulse <= 1'b0;
      end else begin
         state_q     <= state_nx;
         hold_cnt_q  <= hold_cnt_nx;
         trip_cnt_q  <= trip_cnt_nx;
         alarme      <= alarme_nx;
         alarm_pulse <= pulse_nx;
      end
   end

   // Next state: disable beats clear, clear beats a trip; compares use pre-edge registers
   always_comb begin
      state_nx    = state_q;
      hold_cnt_nx = hold_cnt_q;
      trip_cnt_nx = trip_cnt_q;
      pulse_nx    = 1'b0;
      if (disable_pulse) begin
         state_nx    = ST_DISABLED;
         hold_cnt_nx = '0;
      end else if (clear_pulse && (state_q != ST_DISABLED)) begin
         state_nx    = ST_ARMED;
         hold_cnt_nx = '0;
      end else begin
         case (state_q)
            ST_DISABLED: begin
               if (enable) state_nx = ST_ARMED;
            end
            ST_ARMED: begin
               if (cmp_a == cmp_b) begin
                  state_nx    = ST_TRIPPED;
                  hold_cnt_nx = hold;
                  pulse_nx    = 1'b1;
                  if (trip_cnt_q != {CNT_W{1'b1}}) trip_cnt_nx = trip_cnt_q + CNT_W'(1);
               end
            end
            ST_TRIPPED: begin
               if (hold_cnt_q == '0) state_nx = ST_LATCHED;
               else                  hold_cnt_nx = hold_cnt_q - HOLD_W'(1);
            end
            ST_LATCHED: begin
               if (auto_rearm && (cmp_a != cmp_b)) state_nx = ST_ARMED;
            end
            default: state_nx = ST_DISABLED;
         endcase
      end
      alarme_nx = (state_nx == ST_TRIPPED) || (state_nx == ST_LATCHED);
   end

endmodule

// File: tb/tb_mmio_alarm_responder.sv
// Bench for mmio_alarm_responder: directed scenarios plus randomized bus traffic,
// all compared against a behavioural model of the register map and alarm rules.
module tb_mmio_alarm_responder;

   localparam logic [31:0] BASE     = 32'h0000_0100;
   localparam logic [31:0] A_CTRL   = BASE + 32'h00;
   localparam logic [31:0] A_CMPA   = BASE + 32'h04;
   localparam logic [31:0] A_CMPB   = BASE + 32'h08;
   localparam logic [31:0] A_STATUS = BASE + 32'h0C;
   localparam logic [31:0] A_HOLD   = BASE + 32'h10;

   localparam int ST_DIS = 0;
   localparam int ST_ARM = 1;
   localparam int ST_TRP = 2;
   localparam int ST_LAT = 3;

   logic        clk;
   logic        rst_n;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        sel;
   logic [31:0] rdata;
   logic        alarme;
   logic        alarm_pulse;

   int vectors    = 0;
   int miscompares = 0;

   // ---------------- behavioural model ----------------
   logic        m_en, m_ar;
   logic [31:0] m_a, m_b;
   logic [15:0] m_hold;
   int          m_state;
   int          m_left;    // cycles still to spend in TRIPPED
   int          m_cnt;
   logic        m_pulse;

   mmio_alarm_responder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_write   (mem_write),
      .addr        (addr),
      .wdata       (wdata),
      .sel         (sel),
      .rdata       (rdata),
      .alarme      (alarme),
      .alarm_pulse (alarm_pulse)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic m_reset();
      m_en = 1'b0; m_ar = 1'b0; m_a = '0; m_b = '0; m_hold = 16'd4;
      m_state = ST_DIS; m_left = 0; m_cnt = 0; m_pulse = 1'b0;
   endtask

   function automatic logic m_sel(input logic [31:0] a);
      return (a >= BASE) && (a <= BASE + 32'h10) && (a[1:0] == 2'b00);
   endfunction

   function automatic logic m_alarme();
      return (m_state == ST_TRP) || (m_state == ST_LAT);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] r;
      logic [1:0]  st;
      r = '0;
      st = m_state[1:0];
      if (m_sel(a)) begin
         case (a - BASE)
            32'h00: r = {29'd0, m_ar, 1'b0, m_en};
            32'h04: r = m_a;
            32'h08: r = m_b;
            32'h0C: r = {16'd0, m_cnt[7:0], 5'd0, st, m_alarme()};
            32'h10: r = {16'd0, m_hold};
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   // One rising edge of the model, given the bus contents during the cycle
   task automatic m_step(input logic we, input logic [31:0] a, input logic [31:0] d);
      logic        hit, ctrl_w, dis, clr;
      logic [31:0] off;
      hit    = we && m_sel(a);
      off    = a - BASE;
      ctrl_w = hit && (off == 32'h0);
      dis    = ctrl_w && !d[0];
      clr    = ctrl_w && d[1];
      m_pulse = 1'b0;
      if (dis) begin
         m_state = ST_DIS; m_left = 0;
      end else if (clr && m_state != ST_DIS) begin
         m_state = ST_ARM; m_left = 0;
      end else if (m_state == ST_DIS) begin
         if (m_en) m_state = ST_ARM;
      end else if (m_state == ST_ARM) begin
         if (m_a == m_b) begin
            m_state = ST_TRP;
            m_left  = int'(m_hold) + 1;
            m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_pulse = 1'b1;
         end
      end else if (m_state == ST_TRP) begin
         m_left = m_left - 1;
         if (m_left == 0) m_state = ST_LAT;
      end else begin
         if (m_ar && m_a != m_b) m_state = ST_ARM;
      end
      if (hit) begin
         case (off)
            32'h00: begin m_en = d[0]; m_ar = d[2]; end
            32'h04: m_a = d;
            32'h08: m_b = d;
            32'h10: m_hold = d[15:0];
            default: ;
         endcase
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_bus(input logic we, input logic [31:0] a, input logic [31:0] d);
      mem_write = we; addr = a; wdata = d;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) m_step(mem_write, addr, wdata);
      #1;
   endtask

   task automatic sw(input logic [31:0] a, input logic [31:0] d);
      set_bus(1'b1, a, d);
      tick();
   endtask

   task automatic idle(input logic [31:0] a);
      set_bus(1'b0, a, 32'd0);
      tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] exp_v [5];
      logic [31:0] regs [5];
      regs = '{A_CTRL, A_CMPA, A_CMPB, A_STATUS, A_HOLD};
      exp_v = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd4};
      vectors++;
      if (alarme !== 1'b0 || alarm_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got alarme=%b pulse=%b want 0 0", alarme, alarm_pulse);
      end
      for (int i = 0; i < 5; i++) begin
         set_bus(1'b0, regs[i], 32'd0);
         vectors++;
         if (sel !== 1'b1 || rdata !== exp_v[i]) begin
            miscompares++;
            $display("FAIL reset_read[%0d]: got sel=%b rdata=%h want 1 %h", i, sel, rdata, exp_v[i]);
         end
      end
   endtask

   task automatic test_trip_hold();
      sw(A_CTRL, 32'd1);
      sw(A_CMPA, 32'd5);
      sw(A_CMPB, 32'd5);
      vectors++;
      if (alarm_pulse !== 1'b0 || alarme !== 1'b0) begin
         miscompares++;
         $display("FAIL early_trip: got pulse=%b alarme=%b want 0 0", alarm_pulse, alarme);
      end
      idle(A_STATUS);
      vectors++;
      if (alarm_pulse !== 1'b1 || alarme !== 1'b1 || rdata !== 32'h0000_0105) begin
         miscompares++;
         $display("FAIL trip_edge: got pulse=%b alarme=%b status=%h want 1 1 00000105", alarm_pulse, alarme, rdata);
      end
      for (int i = 1; i < 5; i++) begin
         idle(A_STATUS);
         vectors++;
         if (alarm_pulse !== 1'b0 || rdata !== 32'h0000_0105) begin
            miscompares++;
            $display("FAIL tripped_cycle%0d: got pulse=%b status=%h want 0 00000105", i, alarm_pulse, rdata);
         end
      end
      for (int i = 0; i < 3; i++) begin
         idle(A_STATUS);
         vectors++;
         if (alarme !== 1'b1 || rdata !== 32'h0000_0107) begin
            miscompares++;
            $display("FAIL latched%0d: got alarme=%b status=%h want 1 00000107", i, alarme, rdata);
         end
      end
   endtask

   task automatic test_clear_retrip();
      sw(A_CTRL, 32'd3);
      set_bus(1'b0, A_STATUS, 32'd0);
      vectors++;
      if (alarme !== 1'b0 || rdata !== 32'h0000_0102) begin
         miscompares++;
         $display("FAIL clear: got alarme=%b status=%h want 0 00000102", alarme, rdata);
      end
      tick();
      vectors++;
      if (alarm_pulse !== 1'b1 || rdata !== 32'h0000_0205) begin
         miscompares++;
         $display("FAIL retrip: got pulse=%b status=%h want 1 00000205", alarm_pulse, rdata);
      end
      sw(A_CTRL, 32'd0);
      set_bus(1'b0, A_STATUS, 32'd0);
      vectors++;
      if (alarme !== 1'b0 || rdata !== 32'h0000_0200) begin
         miscompares++;
         $display("FAIL disable: got alarme=%b status=%h want 0 00000200", alarme, rdata);
      end
   endtask

   task automatic test_auto_rearm();
      sw(A_HOLD, 32'd0);
      sw(A_CMPA, 32'd7);
      sw(A_CMPB, 32'd7);
      sw(A_CTRL, 32'd5);
      for (int i = 0; i < 4; i++) begin
         idle(A_STATUS);
         vectors++;
         if (rdata !== m_read(A_STATUS) || alarme !== m_alarme() || alarm_pulse !== m_pulse) begin
            miscompares++;
            $display("FAIL hold0_step%0d: got status=%h alarme=%b pulse=%b want %h %b %b",
                     i, rdata, alarme, alarm_pulse, m_read(A_STATUS), m_alarme(), m_pulse);
         end
      end
      vectors++;
      if (rdata !== 32'h0000_0307) begin
         miscompares++;
         $display("FAIL hold0_latched: got status=%h want 00000307", rdata);
      end
      sw(A_CMPB, 32'd8);
      set_bus(1'b0, A_STATUS, 32'd0);
      vectors++;
      if (rdata !== 32'h0000_0307 || alarme !== 1'b1) begin
         miscompares++;
         $display("FAIL rearm_wait: got status=%h alarme=%b want 00000307 1", rdata, alarme);
      end
      tick();
      vectors++;
      if (rdata !== 32'h0000_0302 || alarme !== 1'b0) begin
         miscompares++;
         $display("FAIL rearm: got status=%h alarme=%b want 00000302 0", rdata, alarme);
      end
   endtask

   task automatic test_bad_addr();
      logic [31:0] bad [3];
      logic        exp_sel [3];
      logic [31:0] regs [5];
      bad = '{BASE + 32'h02, BASE + 32'h14, A_STATUS};
      exp_sel = '{1'b0, 1'b0, 1'b1};
      regs = '{A_CTRL, A_CMPA, A_CMPB, A_STATUS, A_HOLD};
      for (int i = 0; i < 3; i++) begin
         set_bus(1'b1, bad[i], 32'hDEAD_BEEF);
         vectors++;
         if (sel !== exp_sel[i] || (!exp_sel[i] && rdata !== 32'd0)) begin
            miscompares++;
            $display("FAIL bad_addr[%0d]: got sel=%b rdata=%h want sel=%b", i, sel, rdata, exp_sel[i]);
         end
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         set_bus(1'b0, regs[i], 32'd0);
         vectors++;
         if (rdata !== m_read(regs[i])) begin
            miscompares++;
            $display("FAIL after_bad[%0d]: got %h want %h", i, rdata, m_read(regs[i]));
         end
      end
   endtask

   task automatic test_saturate();
      sw(A_CTRL, 32'd5);
      sw(A_HOLD, 32'd0);
      sw(A_CMPA, 32'd7);
      sw(A_CMPB, 32'd8);
      idle(A_STATUS);
      for (int i = 0; i < 260; i++) begin
         sw(A_CMPB, 32'd7);
         idle(A_STATUS);
         vectors++;
         if (alarm_pulse !== 1'b1 || rdata !== m_read(A_STATUS)) begin
            miscompares++;
            $display("FAIL sat_trip%0d: got pulse=%b status=%h want 1 %h", i, alarm_pulse, rdata, m_read(A_STATUS));
         end
         idle(A_STATUS);
         sw(A_CMPB, 32'd8);
         idle(A_STATUS);
      end
      vectors++;
      if (rdata[15:8] !== 8'hFF) begin
         miscompares++;
         $display("FAIL saturate: got trip_cnt=%h want ff", rdata[15:8]);
      end
   endtask

   task automatic test_random();
      logic        we;
      logic [31:0] a, d;
      logic [31:0] bad [6];
      bad = '{BASE + 32'h1, BASE + 32'h2, BASE + 32'h3, BASE + 32'h14, BASE - 32'h4, A_STATUS};
      for (int n = 0; n < 800; n++) begin
         we = 1'b0; a = A_STATUS; d = '0;
         case ($urandom_range(0, 9))
            0, 1, 2: a = BASE + 32'($urandom_range(0, 4) * 4);
            3: begin
               we = 1'b1; a = A_CTRL;
               d = {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) != 0)};
            end
            4: begin we = 1'b1; a = A_CMPA; d = 32'($urandom_range(0, 2)); end
            5: begin we = 1'b1; a = A_CMPB; d = 32'($urandom_range(0, 2)); end
            6: begin we = 1'b1; a = A_HOLD; d = 32'($urandom_range(0, 4)); end
            7: begin we = 1'b1; a = bad[$urandom_range(0, 5)]; d = $urandom; end
            default: a = A_STATUS;
         endcase
         set_bus(we, a, d);
         vectors++;
         if (sel !== m_sel(a) || rdata !== m_read(a)) begin
            miscompares++;
            $display("FAIL rnd_read%0d: addr=%h got sel=%b rdata=%h want %b %h", n, a, sel, rdata, m_sel(a), m_read(a));
         end
         tick();
         vectors++;
         if (alarme !== m_alarme() || alarm_pulse !== m_pulse || rdata !== m_read(a)) begin
            miscompares++;
            $display("FAIL rnd_edge%0d: got alarme=%b pulse=%b rdata=%h want %b %b %h",
                     n, alarme, alarm_pulse, rdata, m_alarme(), m_pulse, m_read(a));
         end
      end
   endtask

   task automatic test_async_reset();
      sw(A_CTRL, 32'd0);
      sw(A_HOLD, 32'd10);
      sw(A_CMPA, 32'd1);
      sw(A_CMPB, 32'd1);
      sw(A_CTRL, 32'd1);
      idle(A_STATUS);
      idle(A_STATUS);
      idle(A_STATUS);
      vectors++;
      if (alarme !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_alarm: got alarme=%b want 1", alarme);
      end
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      vectors++;
      if (alarme !== 1'b0 || alarm_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got alarme=%b pulse=%b want 0 0", alarme, alarm_pulse);
      end
      set_bus(1'b0, A_STATUS, 32'd0);
      vectors++;
      if (rdata !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_status: got %h want 00000000", rdata);
      end
      set_bus(1'b0, A_HOLD, 32'd0);
      vectors++;
      if (rdata !== 32'd4) begin
         miscompares++;
         $display("FAIL reset_hold: got %h want 00000004", rdata);
      end
      set_bus(1'b0, A_CTRL, 32'd0);
      vectors++;
      if (rdata !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %h want 00000000", rdata);
      end
      rst_n = 1'b1;
      idle(A_STATUS);
      vectors++;
      if (rdata !== m_read(A_STATUS) || alarme !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset: got status=%h alarme=%b want %h 0", rdata, alarme, m_read(A_STATUS));
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_n = 1'b0;
      m_reset();
      set_bus(1'b0, A_STATUS, 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      test_reset();
      test_trip_hold();
      test_clear_retrip();
      test_auto_rearm();
      test_bad_addr();
      test_saturate();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
